hough_vote_generator: RTL

HOUGH_VOTE_GENERATOR -- requirements
Module: hough_vote_generator

---
 rtl/hough_vote_generator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hough_vote_generator.sv
// Hough line-transform vote generator: reads edge points from a FIFO and emits
// one (theta, rho) vote per 1-degree angle bin per point, with per-frame point counting.
module hough_vote_generator #(
  parameter int unsigned DATA_WIDTH  = 21,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned THETA_STEPS = 180,
  parameter int unsigned TRIG_W      = 12,
  parameter int unsigned RHO_W       = 12,
  parameter int unsigned RHO_OFFSET  = 1448
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  vote_valid,
  input  logic                  vote_ready,
  output logic [7:0]            vote_theta,
  output logic [RHO_W-1:0]      vote_rho,
  output logic                  frame_done,
  output logic [15:0]           frame_points,
  output logic                  busy
);

  localparam int unsigned THETA_W = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned FRAC_W  = TRIG_W - 2;
  localparam int unsigned SUM_W   = COORD_W + TRIG_W + 2;
  localparam logic signed [SUM_W-1:0] ROUND_S  = SUM_W'(1 << (FRAC_W - 1));
  localparam logic signed [SUM_W-1:0] OFFSET_S = SUM_W'(RHO_OFFSET);
  localparam logic [THETA_W-1:0] LAST_THETA = THETA_W'(THETA_STEPS - 1);

  // Quarter-wave table: round(1024*sin(deg)), deg = 0..90
  localparam logic [10:0] SIN_Q [0:90] = '{
       0,   18,   36,   54,   71,   89,  107,  125,  143,  160,
     178,  195,  213,  230,  248,  265,  282,  299,  316,  333,
     350,  367,  384,  400,  416,  433,  449,  465,  481,  496,
     512,  527,  543,  558,  573,  587,  602,  616,  630,  644,
     658,  672,  685,  698,  711,  724,  737,  749,  761,  773,
     784,  796,  807,  818,  828,  839,  849,  859,  868,  878,
     887,  896,  904,  912,  920,  928,  935,  943,  949,  956,
     962,  968,  974,  979,  984,  989,  994,  998, 1002, 1005,
    1008, 1011, 1014, 1016, 1018, 1020, 1022, 1023, 1023, 1024,
    1024
  };

  typedef enum logic [1:0] {IDLE, LOAD, VOTE, EOFW} state_t;

  state_t state, next_state;

  logic                     armed;
  logic [COORD_W-1:0]       x_q, y_q;
  logic [THETA_W-1:0]       theta;
  logic [CNT_W-1:0]         point_cnt;
  logic                     rd_c, latch_c, load_c, close_c, valid_next_c;
  logic signed [TRIG_W-1:0] sin_c, cos_c;
  logic signed [SUM_W-1:0]  sum_c, shifted_c;
  logic [RHO_W-1:0]         rho_c;

  function automatic logic signed [TRIG_W-1:0] quarter_wave(input logic [6:0] deg);
    quarter_wave = $signed(TRIG_W'(SIN_Q[deg]));
  endfunction

  assign fifo_rd_en = rd_c;

  // Fold the 0..179 degree range onto the quarter-wave table
  always_comb begin
    sin_c = '0;
    cos_c = '0;
    if (theta <= THETA_W'(90)) begin
      sin_c = quarter_wave(7'(theta));
      cos_c = quarter_wave(7'(THETA_W'(90) - theta));
    end else begin
      sin_c = quarter_wave(7'(THETA_W'(180) - theta));
      cos_c = -quarter_wave(7'(theta - THETA_W'(90)));
    end
  end

  always_comb begin
    sum_c = SUM_W'($signed({1'b0, x_q})) * SUM_W'(cos_c)
          + SUM_W'($signed({1'b0, y_q})) * SUM_W'(sin_c)
          + ROUND_S;
    shifted_c = sum_c >>> FRAC_W;
    rho_c     = RHO_W'(shifted_c + OFFSET_S);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    rd_c       = 1'b0;
    latch_c    = 1'b0;
    load_c     = 1'b0;
    close_c    = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !fifo_empty) begin
          rd_c       = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (fifo_rd_data[DATA_WIDTH-1]) begin
          next_state = EOFW;
        end else begin
          latch_c    = 1'b1;
          next_state = VOTE;
        end
      end
      VOTE: begin
        if (!vote_valid || vote_ready) begin
          load_c = 1'b1;
          if (theta == LAST_THETA) next_state = IDLE;
        end
      end
      EOFW: begin
        if (!vote_valid) begin
          close_c    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    valid_next_c = load_c | (vote_valid & ~vote_ready);
  end

  // Datapath, output register and frame bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      theta        <= '0;
      point_cnt    <= '0;
      vote_valid   <= 1'b0;
      vote_theta   <= '0;
      vote_rho     <= '0;
      frame_done   <= 1'b0;
      frame_points <= '0;
      busy         <= 1'b0;
    end else begin
      armed      <= 1'b1;
      vote_valid <= valid_next_c;
      frame_done <= close_c;
      busy       <= (next_state != IDLE) || valid_next_c;
      if (latch_c) begin
        x_q   <= fifo_rd_data[COORD_W-1:0];
        y_q   <= fifo_rd_data[2*COORD_W-1:COORD_W];
        theta <= '0;
      end
      if (load_c) begin
        vote_theta <= theta;
        vote_rho   <= rho_c;
        theta      <= theta + THETA_W'(1);
        if (theta == LAST_THETA && point_cnt != {CNT_W{1'b1}})
          point_cnt <= point_cnt + CNT_W'(1);
      end
      if (close_c) begin
        frame_points <= point_cnt;
        point_cnt    <= '0;
      end
    end
  end

endmodule
